// File: rtl/seq_cmp.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per clock, signed or unsigned per transaction.
// Define SEQ_CMP_EARLY_EXIT_EN to finish on the first differing chunk instead of always taking K cycles.
module seq_cmp #(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic         i_signed,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         o_lt,
    output logic         o_eq,
    output logic         o_gt
);

    localparam int K  = N / CHUNK;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    generate
        if ((N % CHUNK) != 0 || K < 1) begin : g_bad_cfg
            $error("seq_cmp: N must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [IW-1:0]   idx;
    logic            decided;
    logic            lt_q;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic            accept;
    logic            chunk_diff;

    assign a_chunk    = a_q[idx*CHUNK +: CHUNK];
    assign b_chunk    = b_q[idx*CHUNK +: CHUNK];
    assign chunk_diff = (a_chunk != b_chunk);
    assign accept     = i_valid && i_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: the default assignment up front keeps this block free of inferred latches.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = SCAN;
            SCAN: begin
                if (idx == '0) state_nx = DONE;
`ifdef SEQ_CMP_EARLY_EXIT_EN
                if (!decided && chunk_diff) state_nx = DONE;
`endif
            end
            DONE: if (o_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: operand registers carry no reset; they are always written at accept before being read.
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q        <= i_a;
            b_q        <= i_b;
            a_q[N-1]   <= i_a[N-1] ^ i_signed;
            b_q[N-1]   <= i_b[N-1] ^ i_signed;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx     <= IW'(K - 1);
            decided <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx     <= IW'(K - 1);
                        decided <= 1'b0;
                        lt_q    <= 1'b0;
                    end
                end
                SCAN: begin
                    // The first differing chunk is sticky; lower chunks cannot override it.
                    if (!decided && chunk_diff) begin
                        decided <= 1'b1;
                        lt_q    <= (a_chunk < b_chunk);
                    end
                    if (idx != '0) idx <= idx - IW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        i_ready = rst && (state == IDLE);
        o_valid = (state == DONE);
        o_lt    = (state == DONE) && decided && lt_q;
        o_gt    = (state == DONE) && decided && !lt_q;
        o_eq    = (state == DONE) && !decided;
    end

endmodule

// File: tb/tb_seq_cmp.sv
// Directed and randomised bench for seq_cmp: a 32/8 instance for the main scenarios and a 2/1 instance
// for the exhaustive small-width sweep. Latency expectations follow SEQ_CMP_EARLY_EXIT_EN when defined.
module tb_seq_cmp;

    localparam int N     = 32;
    localparam int CHUNK = 8;
    localparam int K     = N / CHUNK;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready;
    logic          i_signed = 1'b0;
    logic [N-1:0]  i_a = '0;
    logic [N-1:0]  i_b = '0;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic          o_lt, o_eq, o_gt;

    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_signed = 1'b0;
    logic [1:0]    s_a = '0;
    logic [1:0]    s_b = '0;
    logic          s_ovalid;
    logic          s_oready = 1'b0;
    logic          s_lt, s_eq, s_gt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_cmp #(.N(N), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_signed(i_signed), .i_a(i_a), .i_b(i_b),
        .o_valid(o_valid), .o_ready(o_ready), .o_lt(o_lt), .o_eq(o_eq), .o_gt(o_gt)
    );

    seq_cmp #(.N(2), .CHUNK(1)) dut_small (
        .clk(clk), .rst(rst),
        .i_valid(s_valid), .i_ready(s_ready), .i_signed(s_signed), .i_a(s_a), .i_b(s_b),
        .o_valid(s_ovalid), .o_ready(s_oready), .o_lt(s_lt), .o_eq(s_eq), .o_gt(s_gt)
    );

    // Drives one transaction into the 32-bit instance; returns flags and accept-to-valid latency.
    task automatic do_txn(input logic [N-1:0] a, input logic [N-1:0] b, input logic sgn,
                          output logic [2:0] flags, output int lat);
        int w;
        w = 0;
        while (!i_ready && w < 50) begin @(posedge clk); #1; w++; end
        i_a = a; i_b = b; i_signed = sgn; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        flags = {o_lt, o_eq, o_gt};
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
    endtask

    task automatic do_small(input logic [1:0] a, input logic [1:0] b, input logic sgn,
                            output logic [2:0] flags, output int lat);
        int w;
        w = 0;
        while (!s_ready && w < 50) begin @(posedge clk); #1; w++; end
        s_a = a; s_b = b; s_signed = sgn; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        lat = 0;
        while (!s_ovalid && lat < 50) begin @(posedge clk); #1; lat++; end
        flags = {s_lt, s_eq, s_gt};
        s_oready = 1'b1;
        @(posedge clk); #1;
        s_oready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({i_ready, o_valid, o_lt, o_eq, o_gt, s_ready, s_ovalid} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {i_ready, o_valid, o_lt, o_eq, o_gt, s_ready, s_ovalid});
        end
        rst = 1'b1;
        #1;
        total++;
        if ({i_ready, s_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 11", {i_ready, s_ready});
        end
    endtask

    task automatic test_small_exhaustive();
        logic [1:0] a, b;
        logic [2:0] f, exp;
        int lat, exp_lat;
        for (int sgn = 0; sgn < 2; sgn++) begin
            for (int ai = 0; ai < 4; ai++) begin
                for (int bi = 0; bi < 4; bi++) begin
                    a = 2'(ai); b = 2'(bi);
                    if (sgn == 1)
                        exp = {$signed(a) < $signed(b), a == b, $signed(a) > $signed(b)};
                    else
                        exp = {a < b, a == b, a > b};
                    exp_lat = (EE && (a[1] != b[1])) ? 1 : 2;
                    do_small(a, b, 1'(sgn), f, lat);
                    total++;
                    if (f !== exp || lat != exp_lat) begin
                        bad++;
                        $display("FAIL small s=%0d a=%b b=%b: flags=%b lat=%0d want flags=%b lat=%0d",
                                 sgn, a, b, f, lat, exp, exp_lat);
                    end
                end
            end
        end
        // Hand-computed anchors: signed -2 < 1, unsigned 2 > 1.
        do_small(2'b10, 2'b01, 1'b1, f, lat);
        total++;
        if (f !== 3'b100) begin bad++; $display("FAIL small_signed_m2_1: flags=%b want 100", f); end
        do_small(2'b10, 2'b01, 1'b0, f, lat);
        total++;
        if (f !== 3'b001) begin bad++; $display("FAIL small_unsigned_2_1: flags=%b want 001", f); end
    endtask

    task automatic test_directed();
        logic [N-1:0] av [7];
        logic [N-1:0] bv [7];
        logic         sv [7];
        logic [2:0]   ef [7];
        int           el [7];
        logic [2:0]   f;
        int           lat;
        // {lt,eq,gt}; latency given as (early-exit, constant)
        av[0] = 32'h8000_0000; bv[0] = 32'h7FFF_FFFF; sv[0] = 1; ef[0] = 3'b100; el[0] = EE ? 1 : 4;
        av[1] = 32'h8000_0000; bv[1] = 32'h7FFF_FFFF; sv[1] = 0; ef[1] = 3'b001; el[1] = EE ? 1 : 4;
        av[2] = 32'hDEAD_BEEF; bv[2] = 32'hDEAD_BEEF; sv[2] = 1; ef[2] = 3'b010; el[2] = 4;
        av[3] = 32'hDEAD_BEEF; bv[3] = 32'hDEAD_BEEF; sv[3] = 0; ef[3] = 3'b010; el[3] = 4;
        av[4] = 32'h0000_0010; bv[4] = 32'h0000_0011; sv[4] = 0; ef[4] = 3'b100; el[4] = 4;
        av[5] = 32'h0100_00FF; bv[5] = 32'h0000_FF00; sv[5] = 0; ef[5] = 3'b001; el[5] = EE ? 1 : 4;
        av[6] = 32'h0012_3400; bv[6] = 32'h0012_3500; sv[6] = 1; ef[6] = 3'b100; el[6] = EE ? 3 : 4;
        for (int i = 0; i < 7; i++) begin
            do_txn(av[i], bv[i], sv[i], f, lat);
            total++;
            if (f !== ef[i] || lat != el[i]) begin
                bad++;
                $display("FAIL directed_%0d a=%h b=%h s=%b: flags=%b lat=%0d want flags=%b lat=%0d",
                         i, av[i], bv[i], sv[i], f, lat, ef[i], el[i]);
            end
        end
        do_txn(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, f, lat);
        total++;
        if (f !== 3'b100 || lat != 4) begin
            bad++;
            $display("FAIL signed_m2_m1: flags=%b lat=%0d want flags=100 lat=4", f, lat);
        end
    endtask

    task automatic test_hold();
        int w;
        i_a = 32'd5; i_b = 32'd3; i_signed = 1'b0; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        w = 0;
        while (!o_valid && w < 50) begin @(posedge clk); #1; w++; end
        for (int c = 0; c < 10; c++) begin
            total++;
            if ({o_valid, o_lt, o_eq, o_gt, i_ready} !== 5'b10010) begin
                bad++;
                $display("FAIL hold_cycle_%0d: {valid,lt,eq,gt,ready}=%b want 10010",
                         c, {o_valid, o_lt, o_eq, o_gt, i_ready});
            end
            @(posedge clk); #1;
        end
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
        total++;
        if ({o_valid, o_lt, o_eq, o_gt, i_ready} !== 5'b00001) begin
            bad++;
            $display("FAIL hold_release: {valid,lt,eq,gt,ready}=%b want 00001",
                     {o_valid, o_lt, o_eq, o_gt, i_ready});
        end
    endtask

    task automatic test_reset_mid_scan();
        bit seen;
        i_a = 32'h0000_0001; i_b = 32'h0000_0000; i_signed = 1'b0; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if (i_ready !== 1'b0) begin bad++; $display("FAIL ready_in_reset: got %b want 0", i_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if ({o_valid, o_lt, o_eq, o_gt, i_ready} !== 5'b00001) begin
            bad++;
            $display("FAIL mid_scan_reset: {valid,lt,eq,gt,ready}=%b want 00001",
                     {o_valid, o_lt, o_eq, o_gt, i_ready});
        end
        o_ready = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (o_valid !== 1'b0) seen = 1'b1;
        end
        o_ready = 1'b0;
        total++;
        if (seen) begin bad++; $display("FAIL aborted_result_emitted: o_valid rose, want never"); end
    endtask

    task automatic test_random();
        logic [N-1:0] a, b;
        logic         sgn;
        logic [2:0]   f, exp;
        int           lat, m, exp_lat;
        bit           found;
        for (int it = 0; it < 512; it++) begin
            a = $urandom;
            if (it % 16 == 1)      b = a;
            else if (it % 4 == 0)  b = a ^ (32'h1 << $urandom_range(0, 31));
            else                   b = $urandom;
            sgn = 1'($urandom_range(0, 1));
            if (sgn) exp = {$signed(a) < $signed(b), a == b, $signed(a) > $signed(b)};
            else     exp = {a < b, a == b, a > b};
            m = K; found = 1'b0;
            for (int c = K - 1; c >= 0; c--) begin
                if (!found && a[c*CHUNK +: CHUNK] != b[c*CHUNK +: CHUNK]) begin
                    m = K - c; found = 1'b1;
                end
            end
            exp_lat = EE ? m : K;
            do_txn(a, b, sgn, f, lat);
            total++;
            if (f !== exp || lat != exp_lat) begin
                bad++;
                $display("FAIL random_%0d a=%h b=%h s=%b: flags=%b lat=%0d want flags=%b lat=%0d",
                         it, a, b, sgn, f, lat, exp, exp_lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int  acc [$];
        bit  rdy, flag_bad, seen_valid;
        int  w;
        i_a = 32'h1234_5678; i_b = 32'h1234_5678; i_signed = 1'b0;
        i_valid = 1'b1; o_ready = 1'b1;
        flag_bad = 1'b0; seen_valid = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            rdy = i_ready;
            @(posedge clk); #1;
            if (rdy) acc.push_back(c);
            if (o_valid) begin
                seen_valid = 1'b1;
                if ({o_lt, o_eq, o_gt} !== 3'b010) flag_bad = 1'b1;
            end
        end
        i_valid = 1'b0;
        w = 0;
        while (!i_ready && w < 20) begin @(posedge clk); #1; w++; end
        o_ready = 1'b0;
        total++;
        if (acc.size() < 3 || (acc[1] - acc[0]) != K + 2 || (acc[2] - acc[1]) != K + 2) begin
            bad++;
            $display("FAIL b2b_spacing: accepts=%0d first gaps=%0d,%0d want %0d", acc.size(),
                     (acc.size() > 1) ? acc[1] - acc[0] : -1,
                     (acc.size() > 2) ? acc[2] - acc[1] : -1, K + 2);
        end
        total++;
        if (flag_bad || !seen_valid) begin
            bad++;
            $display("FAIL b2b_flags: bad_flags=%b seen_valid=%b want 0/1", flag_bad, seen_valid);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_small_exhaustive();
        test_directed();
        test_hold();
        test_reset_mid_scan();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
